// File: rtl/machine_csr_file_if.sv
// CSR instruction bus between the decode/writeback stage and the machine CSR file.
// The master drives the access; the slave returns the combinational read data.
interface machine_csr_file_if;
  logic        wr_en_in;
  logic [11:0] csr_addr_in;
  logic [2:0]  csr_op_in;
  logic [31:0] rs1_in;
  logic [4:0]  imm_in;
  logic [31:0] csr_data_out;

  modport master (
    output wr_en_in, csr_addr_in, csr_op_in, rs1_in, imm_in,
    input  csr_data_out
  );

  modport slave (
    input  wr_en_in, csr_addr_in, csr_op_in, rs1_in, imm_in,
    output csr_data_out
  );
endinterface

// File: rtl/machine_csr_file.sv
// Machine-mode CSR file: Zicsr read/modify/write, trap entry/mret updates,
// 64-bit mcycle/minstret counters, interrupt enables/pending and trap target.
module machine_csr_file (
  input  logic                      clk_in,
  input  logic                      rst_in,
  machine_csr_file_if.slave         csr,
  input  logic [31:0]               pc_in,
  input  logic [31:0]               iadder_in,
  input  logic                      i_or_e_in,
  input  logic [3:0]                cause_in,
  input  logic                      set_epc_in,
  input  logic                      set_cause_in,
  input  logic                      mie_clear_in,
  input  logic                      mie_set_in,
  input  logic                      misaligned_exception_in,
  input  logic                      instret_inc_in,
  input  logic                      eirq_in,
  input  logic                      tirq_in,
  input  logic                      sirq_in,
  output logic                      mie_out,
  output logic                      meie_out,
  output logic                      mtie_out,
  output logic                      msie_out,
  output logic                      meip_out,
  output logic                      mtip_out,
  output logic                      msip_out,
  output logic [31:0]               trap_address_out,
  output logic [31:0]               epc_out
);

  localparam logic [11:0] AddrMstatus   = 12'h300;
  localparam logic [11:0] AddrMisa      = 12'h301;
  localparam logic [11:0] AddrMie       = 12'h304;
  localparam logic [11:0] AddrMtvec     = 12'h305;
  localparam logic [11:0] AddrMscratch  = 12'h340;
  localparam logic [11:0] AddrMepc      = 12'h341;
  localparam logic [11:0] AddrMcause    = 12'h342;
  localparam logic [11:0] AddrMtval     = 12'h343;
  localparam logic [11:0] AddrMip       = 12'h344;
  localparam logic [11:0] AddrMcycle    = 12'hB00;
  localparam logic [11:0] AddrMcycleh   = 12'hB80;
  localparam logic [11:0] AddrMinstret  = 12'hB02;
  localparam logic [11:0] AddrMinstreth = 12'hB82;
  localparam logic [11:0] AddrCycle     = 12'hC00;
  localparam logic [11:0] AddrCycleh    = 12'hC80;
  localparam logic [11:0] AddrInstret   = 12'hC02;
  localparam logic [11:0] AddrInstreth  = 12'hC82;
  localparam logic [31:0] MisaValue     = 32'h4000_0100;

  logic        mie_q, mpie_q, meie_q, mtie_q, msie_q, meip_q, mtip_q, msip_q;
  logic [31:0] mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [63:0] mcycle_q, minstret_q;
  logic [63:0] mcycle_d, minstret_d;
  logic [31:0] rdata, src, wdata;
  logic        wr;
  logic        unused_pc;

  // mepc is word aligned, so the low PC bits never reach state
  assign unused_pc = ^pc_in[1:0];

  always_comb begin
    rdata = 32'h0;
    case (csr.csr_addr_in)
      AddrMstatus:                rdata = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
      AddrMisa:                   rdata = MisaValue;
      AddrMie:                    rdata = {20'b0, meie_q, 3'b0, mtie_q, 3'b0, msie_q, 3'b0};
      AddrMtvec:                  rdata = mtvec_q;
      AddrMscratch:               rdata = mscratch_q;
      AddrMepc:                   rdata = mepc_q;
      AddrMcause:                 rdata = mcause_q;
      AddrMtval:                  rdata = mtval_q;
      AddrMip:                    rdata = {20'b0, meip_q, 3'b0, mtip_q, 3'b0, msip_q, 3'b0};
      AddrMcycle,    AddrCycle:   rdata = mcycle_q[31:0];
      AddrMcycleh,   AddrCycleh:  rdata = mcycle_q[63:32];
      AddrMinstret,  AddrInstret: rdata = minstret_q[31:0];
      AddrMinstreth, AddrInstreth: rdata = minstret_q[63:32];
      default:                    rdata = 32'h0;
    endcase
  end

  always_comb begin
    src = csr.csr_op_in[2] ? {27'b0, csr.imm_in} : csr.rs1_in;
    wr  = csr.wr_en_in && (csr.csr_op_in[1:0] != 2'b00);
    case (csr.csr_op_in[1:0])
      2'b01:   wdata = src;
      2'b10:   wdata = rdata | src;
      default: wdata = rdata & ~src;
    endcase
  end

  logic wr_mcycle_lo, wr_mcycle_hi, wr_minstret_lo, wr_minstret_hi;
  assign wr_mcycle_lo   = wr && (csr.csr_addr_in == AddrMcycle);
  assign wr_mcycle_hi   = wr && (csr.csr_addr_in == AddrMcycleh);
  assign wr_minstret_lo = wr && (csr.csr_addr_in == AddrMinstret);
  assign wr_minstret_hi = wr && (csr.csr_addr_in == AddrMinstreth);

  // A written word holds the written value; the high word only takes a carry
  // when the low word is free-running this cycle.
  always_comb begin
    mcycle_d[31:0]  = wr_mcycle_lo ? wdata : mcycle_q[31:0] + 32'd1;
    mcycle_d[63:32] = wr_mcycle_hi ? wdata :
                      (!wr_mcycle_lo && (&mcycle_q[31:0])) ? mcycle_q[63:32] + 32'd1 :
                      mcycle_q[63:32];
    minstret_d[31:0]  = wr_minstret_lo ? wdata :
                        instret_inc_in ? minstret_q[31:0] + 32'd1 : minstret_q[31:0];
    minstret_d[63:32] = wr_minstret_hi ? wdata :
                        (!wr_minstret_lo && instret_inc_in && (&minstret_q[31:0])) ?
                        minstret_q[63:32] + 32'd1 : minstret_q[63:32];
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      meie_q     <= 1'b0;
      mtie_q     <= 1'b0;
      msie_q     <= 1'b0;
      meip_q     <= 1'b0;
      mtip_q     <= 1'b0;
      msip_q     <= 1'b0;
      mtvec_q    <= 32'h0;
      mscratch_q <= 32'h0;
      mepc_q     <= 32'h0;
      mcause_q   <= 32'h0;
      mtval_q    <= 32'h0;
      mcycle_q   <= 64'h0;
      minstret_q <= 64'h0;
    end else begin
      meip_q     <= eirq_in;
      mtip_q     <= tirq_in;
      msip_q     <= sirq_in;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;

      if (mie_clear_in) begin
        mpie_q <= mie_q;
        mie_q  <= 1'b0;
      end else if (mie_set_in) begin
        mie_q  <= mpie_q;
        mpie_q <= 1'b1;
      end else if (wr && (csr.csr_addr_in == AddrMstatus)) begin
        mie_q  <= wdata[3];
        mpie_q <= wdata[7];
      end

      if (wr && (csr.csr_addr_in == AddrMie)) begin
        meie_q <= wdata[11];
        mtie_q <= wdata[7];
        msie_q <= wdata[3];
      end

      // Bit1 is hard-wired low so only direct and vectored modes exist
      if (wr && (csr.csr_addr_in == AddrMtvec)) mtvec_q <= {wdata[31:2], 1'b0, wdata[0]};
      if (wr && (csr.csr_addr_in == AddrMscratch)) mscratch_q <= wdata;

      if (set_epc_in) mepc_q <= {pc_in[31:2], 2'b00};
      else if (wr && (csr.csr_addr_in == AddrMepc)) mepc_q <= {wdata[31:2], 2'b00};

      if (set_cause_in) begin
        mcause_q <= {i_or_e_in, 27'b0, cause_in};
        mtval_q  <= misaligned_exception_in ? iadder_in : 32'h0;
      end else begin
        if (wr && (csr.csr_addr_in == AddrMcause)) mcause_q <= wdata;
        if (wr && (csr.csr_addr_in == AddrMtval))  mtval_q  <= wdata;
      end
    end
  end

  assign csr.csr_data_out = rdata;
  assign mie_out          = mie_q;
  assign meie_out         = meie_q;
  assign mtie_out         = mtie_q;
  assign msie_out         = msie_q;
  assign meip_out         = meip_q;
  assign mtip_out         = mtip_q;
  assign msip_out         = msip_q;
  assign epc_out          = mepc_q;
  assign trap_address_out = (mtvec_q[0] && i_or_e_in) ?
                            {mtvec_q[31:2], 2'b00} + {26'b0, cause_in, 2'b00} :
                            {mtvec_q[31:2], 2'b00};

endmodule

// File: doc/machine_csr_file.md
# machine_csr_file

Machine-mode CSR register file for the stage 2 RISC-V core. It holds mstatus, mie, mip, mtvec, mscratch, mepc, mcause, mtval, mcycle and minstret. It executes Zicsr read/modify/write operations and applies trap-entry and mret updates requested by machine_control. It returns the interrupt enables and pending bits to machine_control, and returns the trap and return targets to PC generation.

## Interface
- No parameters. All addresses and widths are fixed: RV32, 12-bit CSR address.
- Clock and reset:
  - clk_in  in  1  core clock; all state updates on the rising edge.
  - rst_in  in  1  asynchronous, active-high reset.
- CSR instruction inputs:
  - wr_en_in  in  1  CSR instruction writeback enable.
  - csr_addr_in  in  12  CSR address.
  - csr_op_in  in  3  funct3 of the CSR instruction.
  - rs1_in  in  32  register source operand.
  - imm_in  in  5  zimm field.
- Trap inputs:
  - pc_in  in  32  PC of the trapping or current instruction.
  - iadder_in  in  32  faulting address for misaligned exceptions.
  - i_or_e_in  in  1  1 = interrupt, 0 = exception.
  - cause_in  in  4  trap cause code.
- Control inputs from machine_control:
  - set_epc_in, set_cause_in, mie_clear_in, mie_set_in, misaligned_exception_in, instret_inc_in  in  1 each.
- Interrupt request inputs:
  - eirq_in, tirq_in, sirq_in  in  1 each  raw external, timer and software IRQs.
- Outputs:
  - csr_data_out  out  32  combinational read data.
  - mie_out  out  1  mstatus.MIE.
  - meie_out, mtie_out, msie_out  out  1 each  mie register enable bits.
  - meip_out, mtip_out, msip_out  out  1 each  registered pending bits.
  - trap_address_out  out  32  trap target.
  - epc_out  out  32  mepc value, used as the mret target.

## Operation
- Address map:
  - 0x300 mstatus: MIE bit3, MPIE bit7, MPP[12:11] reads 2'b11, all other bits read 0.
  - 0x301 misa: read-only 0x40000100.
  - 0x304 mie: MSIE bit3, MTIE bit7, MEIE bit11.
  - 0x305 mtvec.
  - 0x340 mscratch.
  - 0x341 mepc: bits[1:0] always 0.
  - 0x342 mcause.
  - 0x343 mtval.
  - 0x344 mip: read-only, MSIP bit3, MTIP bit7, MEIP bit11.
  - 0xB00/0xB80 mcycle low/high. 0xB02/0xB82 minstret low/high.
  - 0xC00/0xC80/0xC02/0xC82: read-only aliases of the counters.
  - Any unmapped address reads 0; writes to it are ignored.
- Write data by csr_op_in, where src = rs1_in for ops 001/010/011 and {27'b0, imm_in} for ops 101/110/111:
  - 001/101: new = src.
  - 010/110: new = old | src.
  - 011/111: new = old & ~src.
  - Any other op: no write.
- A write occurs only when wr_en_in=1. Writes to read-only addresses are ignored.
- Writes to mtvec force bit1 to 0. Valid modes are 00 (direct) and 01 (vectored).
- Trap entry updates:
  - mie_clear_in: MPIE <= MIE, MIE <= 0.
  - mie_set_in (mret): MIE <= MPIE, MPIE <= 1.
  - set_epc_in: mepc <= {pc_in[31:2], 2'b00}.
  - set_cause_in: mcause <= {i_or_e_in, 27'b0, cause_in}. In the same cycle, mtval <= misaligned_exception_in ? iadder_in : 0.
- Precedence: a trap update takes precedence over a CSR write to the same register in the same cycle. A CSR write to a counter word takes precedence over that word's increment in the same cycle.
- Counters:
  - mcycle is 64 bits and increments every cycle.
  - minstret is 64 bits and increments when instret_inc_in=1.
  - Both wrap from 0xFFFF_FFFF_FFFF_FFFF to 0.
  - A carry from the low word into the high word happens only when the low word is not being written.
- Pending bits: meip/mtip/msip <= eirq_in/tirq_in/sirq_in every cycle.
- trap_address_out, with base = {mtvec[31:2], 2'b00}:
  - Direct mode, or i_or_e_in=0: base.
  - Vectored mode with i_or_e_in=1: base + (cause_in << 2).
- epc_out = mepc.

## Timing
- Reset: every register is 0, including counters and pending bits. All outputs are therefore 0 except csr_data_out, which is 0 for every address except mstatus (0x1800) and misa.
- Reset is asynchronous. Asserting it in the middle of a write discards the write.
- Reads are combinational from the current state. A write is visible on csr_data_out in the cycle after the edge.
- Interrupt pending bits lag the IRQ inputs by exactly 1 cycle.
- trap_address_out is combinational from mtvec, i_or_e_in and cause_in.
- mcycle read in cycle N after reset deassertion returns N.

## Test plan
- Reset, then read 0x300, 0x301 and 0xB00 on three consecutive cycles. Required: 0x00001800, 0x40000100, 2.
- CSRRW 0x305 with rs1=0x00000103, then i_or_e=1 and cause=7. Required: mtvec reads 0x00000101 and trap_address_out = 0x0000011C. With i_or_e=0, trap_address_out = 0x00000100.
- Set MIE=1, then assert mie_clear, set_epc (pc=0x80000046) and set_cause (exception, cause=4, misaligned, iadder=0x2003) together, alongside a CSRRW to mepc=0xFFFFFFFF. Required:
  - MIE=0, MPIE=1.
  - mepc=0x80000044; the trap update wins over the CSR write.
  - mcause=0x00000004, mtval=0x2003.
- After that, pulse mie_set. Required: MIE=1 and MPIE=1.
- CSRRS mie with rs1=0x888, then CSRRC with zimm=0x8. Required: mie reads 0x888 and then 0x880. Pulse tirq_in for 1 cycle; mtip_out is high exactly 1 cycle later, for 1 cycle.
- CSRRW minstret low with 0xFFFFFFFF, then pulse instret_inc twice. Required: minstreth=1, minstret=1. A CSRRW to mcycle in the same cycle as its increment leaves the written value, and the read in the next cycle returns it.
